// File: rtl/aha_wdog_kicker.sv
// AHB-Lite master that runs unlock / interrupt-clear / relock writes on the CMSDK watchdog.
// Request to DONE takes 8 cycles with no wait states; every phase holds until HREADY=1.
module aha_wdog_kicker #(
  parameter logic [31:0] WDOG_BASE = 32'h4000_0000,
  parameter logic [31:0] LOCK_KEY  = 32'h1ACC_E551,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             ENABLE,
  input  logic [CNT_W-1:0] PERIOD,
  input  logic             KICK_REQ,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  input  logic [31:0]      HRDATA,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [15:0]      KICK_COUNT
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_A_UNL = 3'd1;
  localparam logic [2:0] S_D_UNL = 3'd2;
  localparam logic [2:0] S_A_CLR = 3'd3;
  localparam logic [2:0] S_D_CLR = 3'd4;
  localparam logic [2:0] S_A_LCK = 3'd5;
  localparam logic [2:0] S_D_LCK = 3'd6;
  localparam logic [2:0] S_FIN   = 3'd7;

  localparam logic [1:0]       TR_IDLE   = 2'b00;
  localparam logic [1:0]       TR_NONSEQ = 2'b10;
  localparam logic [31:0]      ADDR_LOCK = WDOG_BASE + 32'h0000_0C00;
  localparam logic [31:0]      ADDR_ICLR = WDOG_BASE + 32'h0000_000C;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [31:0]      haddr_q, haddr_d;
  logic [1:0]       htrans_q, htrans_d;
  logic             hwrite_q, hwrite_d;
  logic [31:0]      hwdata_q, hwdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [15:0]      kcnt_q, kcnt_d;

  logic [CNT_W-1:0] cnt_cur;
  logic             tick;
  logic             take;
  logic             dphase;
  logic             err_hit;
  logic             addr_phase_d;
  logic             unused_hrdata;

  assign unused_hrdata = ^HRDATA;

  always_comb begin
    run_d   = 1'b0;
    cnt_d   = cnt_q;
    tick    = 1'b0;
    // While idle the counter is logically parked at PERIOD, so the first interval is a full one.
    cnt_cur = run_q ? cnt_q : PERIOD;
    if (ENABLE && (PERIOD != '0)) begin
      run_d = 1'b1;
      if (cnt_cur == '0) begin
        tick  = 1'b1;
        cnt_d = PERIOD - CNT_ONE;
      end else begin
        cnt_d = cnt_cur - CNT_ONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    dphase  = (state_q == S_D_UNL) || (state_q == S_D_CLR) || (state_q == S_D_LCK);
    err_hit = dphase && HRESP;
    unique case (state_q)
      S_IDLE:  if (pend_q) begin
                 state_d = S_A_UNL;
                 take    = 1'b1;
               end
      S_A_UNL: if (HREADY) state_d = S_D_UNL;
      S_D_UNL: if (HREADY) state_d = (HRESP || err_q) ? S_A_LCK : S_A_CLR;
      S_A_CLR: if (HREADY) state_d = S_D_CLR;
      // A failed unlock or clear still goes on to relock the watchdog.
      S_D_CLR: if (HREADY) state_d = (HRESP || err_q) ? S_A_LCK : S_A_CLR + 3'd2;
      S_A_LCK: if (HREADY) state_d = S_D_LCK;
      S_D_LCK: if (HREADY) state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase

    pend_d = (pend_q && !take) || KICK_REQ || tick;
    err_d  = (state_q == S_FIN) ? 1'b0 : (err_q || err_hit);
  end

  always_comb begin
    addr_phase_d = (state_d == S_A_UNL) || (state_d == S_A_CLR) || (state_d == S_A_LCK);
    htrans_d     = addr_phase_d ? TR_NONSEQ : TR_IDLE;
    hwrite_d     = addr_phase_d;
    haddr_d      = haddr_q;
    hwdata_d     = hwdata_q;
    unique case (state_d)
      S_A_UNL, S_A_LCK: haddr_d  = ADDR_LOCK;
      S_A_CLR:          haddr_d  = ADDR_ICLR;
      S_D_UNL:          hwdata_d = LOCK_KEY;
      S_D_CLR:          hwdata_d = 32'h0000_0001;
      S_D_LCK:          hwdata_d = 32'h0000_0000;
      default:          ;
    endcase
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    error_d = (state_d == S_FIN) && (err_q || err_hit);
    kcnt_d  = (state_d == S_FIN) ? kcnt_q + 16'd1 : kcnt_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      haddr_q  <= 32'h0;
      htrans_q <= TR_IDLE;
      hwrite_q <= 1'b0;
      hwdata_q <= 32'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      kcnt_q   <= 16'h0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      kcnt_q   <= kcnt_d;
    end
  end

  assign HADDR      = haddr_q;
  assign HTRANS     = htrans_q;
  assign HWRITE     = hwrite_q;
  assign HSIZE      = 3'b010;
  assign HBURST     = 3'b000;
  assign HPROT      = 4'b0011;
  assign HMASTLOCK  = 1'b0;
  assign HWDATA     = hwdata_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERROR      = error_q;
  assign KICK_COUNT = kcnt_q;

endmodule
